ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage OpenMIPS pipeline. It sits directly downstream of the decode stage and contains the ID/EX pipeline register, the single-cycle ALU (logic, shift, move, arithmetic) and a 32-iteration shift-add multiplier. Its results go to the EX/MEM register and are fed back combinationally to decode for forwarding. While a multiply is in flight it raises a stall that freezes PC, IF/ID and decode.

## Interface

**Parameters**
- MUL_CYCLES, 32: iterations of the multiplier, one product bit per cycle.

**Ports**
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- aluop_i  in  8  operation code from decode.
- alusel_i  in  3  result class from decode: NOP, LOGIC, SHIFT, MOVE, ARITHMETIC, MUL.
- reg1_i  in  32  operand 1 (rs or immediate/sa).
- reg2_i  in  32  operand 2 (rt or immediate).
- wd_i  in  5  destination register.
- wreg_i  in  1  destination write enable.
- hi_i  in  32  current HI value (MEM/WB forwarding resolved at top level).
- lo_i  in  32  current LO value (MEM/WB forwarding resolved at top level).
- stall_o  out  1  freeze request to PC, IF/ID and decode.
- wd_o  out  5  destination to EX/MEM; also decode's ex_wd_i.
- wreg_o  out  1  write enable to EX/MEM; also decode's ex_wreg_i.
- wdata_o  out  32  result to EX/MEM; also decode's ex_wdata_i.
- whilo_o  out  1  HI/LO write enable.
- hi_o  out  32  HI write value.
- lo_o  out  32  LO write value.

## Operation

**ID/EX latch**
- Captures aluop/alusel/reg1/reg2/wd/wreg every edge while stall_o=0.
- Holds while stall_o=1.
- On rst it loads NOP: aluop=NOP, alusel=NOP, wd=0, wreg=0, operands 0.

**Single-cycle ALU** (result is combinational from the latch)
- Logic: OR, AND, XOR, NOR.
- Shift: value = reg2, amount = reg1[4:0]. SLL, SRL, SRA (arithmetic fill).
- Move:
  - MFHI → hi_i; MFLO → lo_i.
  - MOVN/MOVZ → reg1, with wreg as decided by decode.
  - MTHI: whilo_o=1, hi_o=reg1, lo_o=lo_i.
  - MTLO: whilo_o=1, hi_o=hi_i, lo_o=reg1.
- Arithmetic: 32-bit wrap-around add/sub.
  - ADD/ADDI/SUB: on signed overflow, wreg_o forced to 0 (result discarded).
  - ADDU/ADDIU/SUBU: never trap.
  - SLT: signed compare. SLTU: unsigned compare. Result is 0 or 1.
  - CLZ/CLO: count leading zeros/ones of reg1, range 0..32.
- NOP or unknown aluop: wdata_o=0, whilo_o=0.

**Multiply FSM** (MULT, MULTU, MUL)
- IDLE: a multiply op in the latch asserts stall_o. Load |reg1| and |reg2| (raw values for MULTU) and record the sign flag. → BUSY, count=0.
- BUSY: one add-shift per cycle; stall_o=1; wreg_o=0, whilo_o=0 (bubble to MEM). When count = MUL_CYCLES-1 → DONE.
- DONE: stall_o=0.
  - Negate the 64-bit product if the signs differ (signed ops only).
  - MULT/MULTU: whilo_o=1, {hi_o,lo_o} = product.
  - MUL: wdata_o = product[31:0] to wd, wreg per decode, whilo_o=0.
  - → IDLE; the latch captures the next instruction on this edge.
- Reset in any state → IDLE, count=0, latch NOP, stall_o=0.

## Timing

- Reset values of all outputs: stall_o=0, wd_o=0, wreg_o=0, wdata_o=0, whilo_o=0, hi_o=0, lo_o=0.
- Single-cycle ops: result is valid the cycle after decode presents the op (throughput 1/cycle). Back-to-back dependent ops forward with no stall.
- Multiply: stall_o is high for 1+MUL_CYCLES = 33 cycles; the result appears in cycle 34 after capture.
- The instruction waiting in decode sees the MUL result via forwarding in the DONE cycle.
- During BUSY, wreg_o=0, so decode never forwards a partial product.
- Signed edge cases:
  - 0x80000000 × 0x80000000 (MULT) = 0x40000000_00000000.
  - A zero operand with a differing sign gives 0; negation of zero stays zero.

## Structure

- aluop/alusel encodings, ZeroWord, RstEnable, WriteEnable and bus widths come from the shared defines.v.
- The multiplier datapath and counter form one sub-module, mult_iter:
  - Inputs: start, signed, opa, opb.
  - Outputs: busy, done, product[63:0].
- ex_stage owns the latch, the ALU and the stall/bubble muxing.

## Test plan

1. Reset: hold rst for 2 cycles with a valid OR op presented → all outputs 0 and stall_o=0; after release, the OR result appears next cycle.
2. ADD 0x7FFFFFFF + 1 → wreg_o=0. ADDU with the same operands → wreg_o=1, wdata_o=0x80000000.
3. Shift and count ops:
   - SRA reg1=4, reg2=0xF0000000 → 0xFF000000.
   - CLZ of 0 → 32.
   - CLO of 0xFFFF0000 → 16.
4. MULT -3 × 5 → stall_o high for exactly 33 cycles; then whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. MULTU with the same operands → hi_o=0x00000004, lo_o=0xFFFFFFF1.
5. MUL 0x00010000 × 0x00010003 to r5, followed by dependent ADDU r6=r5+r0 → r5 = 0x00030000; the ADDU result 0x00030000 appears the cycle after DONE.
6. Assert rst at BUSY count 10 → stall_o=0 on the next cycle, no HI/LO write, and a fresh MULT afterwards completes correctly.

Source files
------------

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_pkg
//  Description : Shared encodings, bus widths and helpers for the OpenMIPS
//                execute stage (aluop/alusel codes, ID/EX record, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

    // Bus widths
    localparam int REG_W    = 32;
    localparam int ADDR_W   = 5;
    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    // Common values
    localparam logic [REG_W-1:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic             RST_ENABLE    = 1'b1;
    localparam logic             WRITE_ENABLE  = 1'b1;
    localparam logic             WRITE_DISABLE = 1'b0;

    // Result classes
    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP        = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [ALUSEL_W-1:0] EXE_RES_ARITHMETIC = 3'b100;
    localparam logic [ALUSEL_W-1:0] EXE_RES_MUL        = 3'b101;

    // Operation codes
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] EXE_MOVZ_OP  = 8'b0000_1010;
    localparam logic [ALUOP_W-1:0] EXE_MOVN_OP  = 8'b0000_1011;
    localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [ALUOP_W-1:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [ALUOP_W-1:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [ALUOP_W-1:0] EXE_ADDI_OP  = 8'b0101_0101;
    localparam logic [ALUOP_W-1:0] EXE_ADDIU_OP = 8'b0101_0110;
    localparam logic [ALUOP_W-1:0] EXE_CLZ_OP   = 8'b1011_0000;
    localparam logic [ALUOP_W-1:0] EXE_CLO_OP   = 8'b1011_0001;
    localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [ALUOP_W-1:0] EXE_MUL_OP   = 8'b1010_1001;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [REG_W-1:0]    reg1;
        logic [REG_W-1:0]    reg2;
        logic [ADDR_W-1:0]   wd;
        logic                wreg;
    } idex_t;

    localparam idex_t IDEX_NOP = '{EXE_NOP_OP, EXE_RES_NOP, ZERO_WORD,
                                   ZERO_WORD, 5'd0, WRITE_DISABLE};

    // Iterative multiplier sequencing
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Length of the leading run of 'ones' (CLO) or zeros (CLZ), 0..32
    function automatic logic [5:0] count_lead(input logic [REG_W-1:0] v,
                                              input logic ones);
        logic [5:0] n;
        logic       run;
        n   = 6'd0;
        run = 1'b1;
        for (int i = REG_W - 1; i >= 0; i--) begin
            if (run && (v[i] == ones)) begin
                n = n + 6'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_if
//  Description : Decode-to-execute operand bus plus execute results that go
//                to EX/MEM and back to decode for forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_if;
    import ex_stage_pkg::*;

    // Decode -> execute
    logic [ALUOP_W-1:0]  aluop_i;
    logic [ALUSEL_W-1:0] alusel_i;
    logic [REG_W-1:0]    reg1_i;
    logic [REG_W-1:0]    reg2_i;
    logic [ADDR_W-1:0]   wd_i;
    logic                wreg_i;
    logic [REG_W-1:0]    hi_i;
    logic [REG_W-1:0]    lo_i;

    // Execute -> EX/MEM, decode forwarding and pipeline control
    logic                stall_o;
    logic [ADDR_W-1:0]   wd_o;
    logic                wreg_o;
    logic [REG_W-1:0]    wdata_o;
    logic                whilo_o;
    logic [REG_W-1:0]    hi_o;
    logic [REG_W-1:0]    lo_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
        input  stall_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i,
        output stall_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o
    );

endinterface
`default_nettype wire

// File: rtl/ex_stage_mult_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_iter
//  Description : Shift-add multiplier, one product bit per cycle. Operates
//                on magnitudes and re-applies the sign on the way out.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_iter
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [REG_W-1:0] opa_i,
    input  logic [REG_W-1:0] opb_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [63:0]      product_o
);

    localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [REG_W-1:0]   mcand_q, mcand_d;
    logic [63:0]        acc_q, acc_d;
    logic               neg_q, neg_d;

    logic [REG_W-1:0]   w_abs_a, w_abs_b;
    logic [REG_W:0]     w_upper;

    assign w_abs_a = (signed_i && opa_i[REG_W-1]) ? (~opa_i + 32'd1) : opa_i;
    assign w_abs_b = (signed_i && opb_i[REG_W-1]) ? (~opb_i + 32'd1) : opb_i;

    // Upper half plus the multiplicand when the current multiplier bit is set;
    // the low half of acc holds the not-yet-consumed multiplier bits.
    assign w_upper = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mcand_q : ZERO_WORD)};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= MUL_IDLE;
            count_q <= '0;
            mcand_q <= ZERO_WORD;
            acc_q   <= 64'd0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
        end
    end

    // Next-state and iteration datapath
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    mcand_d = w_abs_a;
                    acc_d   = {ZERO_WORD, w_abs_b};
                    neg_d   = signed_i & (opa_i[REG_W-1] ^ opb_i[REG_W-1]);
                    count_d = '0;
                    state_d = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                acc_d   = {w_upper, acc_q[REG_W-1:1]};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_LAST) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q == MUL_BUSY);
    assign done_o    = (state_q == MUL_DONE);
    // Two's-complement negation leaves a zero product at zero
    assign product_o = neg_q ? (~acc_q + 64'd1) : acc_q;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : OpenMIPS execute stage: ID/EX register, single-cycle ALU and
//                stall/bubble control around the iterative multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);

    idex_t            idex_q, idex_d;

    logic             w_stall;
    logic             w_is_mul;
    logic             w_mul_signed;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [63:0]      w_product;

    logic [REG_W-1:0] w_r1, w_r2;
    logic [4:0]       w_sh;
    logic             w_is_sub;
    logic [REG_W-1:0] w_sum;
    logic             w_ov_add, w_ov_sub;
    logic             w_slt, w_sltu;

    logic             w_wreg;
    logic [REG_W-1:0] w_wdata;
    logic             w_whilo;
    logic [REG_W-1:0] w_hi, w_lo;

    // Latch next-state: take decode's operands unless the pipe is frozen
    always_comb begin
        idex_d = idex_q;
        if (!w_stall) begin
            idex_d.aluop  = bus.aluop_i;
            idex_d.alusel = bus.alusel_i;
            idex_d.reg1   = bus.reg1_i;
            idex_d.reg2   = bus.reg2_i;
            idex_d.wd     = bus.wd_i;
            idex_d.wreg   = bus.wreg_i;
        end
    end

    // ID/EX pipeline register, reset to a bubble
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            idex_q <= IDEX_NOP;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign w_is_mul = (idex_q.alusel == EXE_RES_MUL) &&
                      ((idex_q.aluop == EXE_MULT_OP) ||
                       (idex_q.aluop == EXE_MULTU_OP) ||
                       (idex_q.aluop == EXE_MUL_OP));
    assign w_mul_signed = (idex_q.aluop != EXE_MULTU_OP);

    // Freeze from the cycle a multiply is latched until its DONE cycle
    assign w_stall = w_mul_busy | (w_is_mul & ~w_mul_done);

    mult_iter #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .start_i   (w_is_mul),
        .signed_i  (w_mul_signed),
        .opa_i     (idex_q.reg1),
        .opb_i     (idex_q.reg2),
        .busy_o    (w_mul_busy),
        .done_o    (w_mul_done),
        .product_o (w_product)
    );

    assign w_r1     = idex_q.reg1;
    assign w_r2     = idex_q.reg2;
    assign w_sh     = idex_q.reg1[4:0];
    assign w_is_sub = (idex_q.aluop == EXE_SUB_OP) || (idex_q.aluop == EXE_SUBU_OP);
    assign w_sum    = w_is_sub ? (w_r1 - w_r2) : (w_r1 + w_r2);
    // Signed overflow: like-signed add or unlike-signed subtract flips the sign
    assign w_ov_add = (w_r1[REG_W-1] == w_r2[REG_W-1]) && (w_sum[REG_W-1] != w_r1[REG_W-1]);
    assign w_ov_sub = (w_r1[REG_W-1] != w_r2[REG_W-1]) && (w_sum[REG_W-1] != w_r1[REG_W-1]);
    assign w_slt    = ($signed(w_r1) < $signed(w_r2));
    assign w_sltu   = (w_r1 < w_r2);

    // Result selection by class; multiply results only leave in DONE
    always_comb begin
        w_wreg  = idex_q.wreg;
        w_wdata = ZERO_WORD;
        w_whilo = 1'b0;
        w_hi    = ZERO_WORD;
        w_lo    = ZERO_WORD;
        case (idex_q.alusel)
            EXE_RES_LOGIC: begin
                case (idex_q.aluop)
                    EXE_OR_OP:  w_wdata = w_r1 | w_r2;
                    EXE_AND_OP: w_wdata = w_r1 & w_r2;
                    EXE_XOR_OP: w_wdata = w_r1 ^ w_r2;
                    EXE_NOR_OP: w_wdata = ~(w_r1 | w_r2);
                    default:    w_wdata = ZERO_WORD;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (idex_q.aluop)
                    EXE_SLL_OP: w_wdata = w_r2 << w_sh;
                    EXE_SRL_OP: w_wdata = w_r2 >> w_sh;
                    EXE_SRA_OP: w_wdata = $unsigned($signed(w_r2) >>> w_sh);
                    default:    w_wdata = ZERO_WORD;
                endcase
            end
            EXE_RES_MOVE: begin
                case (idex_q.aluop)
                    EXE_MFHI_OP: w_wdata = bus.hi_i;
                    EXE_MFLO_OP: w_wdata = bus.lo_i;
                    EXE_MOVZ_OP,
                    EXE_MOVN_OP: w_wdata = w_r1;
                    EXE_MTHI_OP: begin
                        w_whilo = 1'b1;
                        w_hi    = w_r1;
                        w_lo    = bus.lo_i;
                    end
                    EXE_MTLO_OP: begin
                        w_whilo = 1'b1;
                        w_hi    = bus.hi_i;
                        w_lo    = w_r1;
                    end
                    default: w_wdata = ZERO_WORD;
                endcase
            end
            EXE_RES_ARITHMETIC: begin
                case (idex_q.aluop)
                    EXE_ADD_OP, EXE_ADDI_OP: begin
                        w_wdata = w_sum;
                        if (w_ov_add) w_wreg = WRITE_DISABLE;
                    end
                    EXE_SUB_OP: begin
                        w_wdata = w_sum;
                        if (w_ov_sub) w_wreg = WRITE_DISABLE;
                    end
                    EXE_ADDU_OP, EXE_ADDIU_OP, EXE_SUBU_OP: w_wdata = w_sum;
                    EXE_SLT_OP:  w_wdata = {31'd0, w_slt};
                    EXE_SLTU_OP: w_wdata = {31'd0, w_sltu};
                    EXE_CLZ_OP:  w_wdata = {26'd0, count_lead(w_r1, 1'b0)};
                    EXE_CLO_OP:  w_wdata = {26'd0, count_lead(w_r1, 1'b1)};
                    default:     w_wdata = ZERO_WORD;
                endcase
            end
            EXE_RES_MUL: begin
                if (w_mul_done) begin
                    if (idex_q.aluop == EXE_MUL_OP) begin
                        w_wdata = w_product[REG_W-1:0];
                    end else begin
                        w_whilo = 1'b1;
                        w_hi    = w_product[63:32];
                        w_lo    = w_product[REG_W-1:0];
                    end
                end else begin
                    w_wreg = WRITE_DISABLE;
                end
            end
            default: begin
                w_wdata = ZERO_WORD;
            end
        endcase
    end

    assign bus.stall_o = w_stall;
    assign bus.wd_o    = idex_q.wd;
    assign bus.wreg_o  = w_wreg;
    assign bus.wdata_o = w_wdata;
    assign bus.whilo_o = w_whilo;
    assign bus.hi_o    = w_hi;
    assign bus.lo_o    = w_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage: directed plan steps plus
//                randomized ALU and multiply traffic against a plain
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if ifc ();

    ex_stage #(
        .MUL_CYCLES (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic [7:0] op_tab [22] = '{
        EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
        EXE_SRA_OP, EXE_MOVZ_OP, EXE_MOVN_OP, EXE_MFHI_OP, EXE_MFLO_OP,
        EXE_MTHI_OP, EXE_MTLO_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_ADD_OP,
        EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP, EXE_ADDI_OP, EXE_CLZ_OP, EXE_CLO_OP
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] sel_of(input logic [7:0] op);
        case (op)
            EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP:   return EXE_RES_LOGIC;
            EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:              return EXE_RES_SHIFT;
            EXE_MOVZ_OP, EXE_MOVN_OP, EXE_MFHI_OP, EXE_MFLO_OP,
            EXE_MTHI_OP, EXE_MTLO_OP:                        return EXE_RES_MOVE;
            EXE_MULT_OP, EXE_MULTU_OP, EXE_MUL_OP:           return EXE_RES_MUL;
            EXE_NOP_OP:                                      return EXE_RES_NOP;
            default:                                         return EXE_RES_ARITHMETIC;
        endcase
    endfunction

    // Reference behaviour written directly from the instruction definitions
    function automatic exp_t ref_alu(input logic [7:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic wreg,
                                     input logic [31:0] hi, input logic [31:0] lo);
        exp_t   e;
        longint s;
        int     sh;
        int     n;
        e.wreg = wreg; e.wdata = 32'd0; e.whilo = 1'b0; e.hi = 32'd0; e.lo = 32'd0;
        sh = int'(a % 32);
        case (op)
            EXE_OR_OP:   e.wdata = a | b;
            EXE_AND_OP:  e.wdata = a & b;
            EXE_XOR_OP:  e.wdata = a ^ b;
            EXE_NOR_OP:  e.wdata = ~(a | b);
            EXE_SLL_OP:  e.wdata = b << sh;
            EXE_SRL_OP:  e.wdata = b >> sh;
            EXE_SRA_OP:  e.wdata = $unsigned($signed(b) >>> sh);
            EXE_MOVZ_OP, EXE_MOVN_OP: e.wdata = a;
            EXE_MFHI_OP: e.wdata = hi;
            EXE_MFLO_OP: e.wdata = lo;
            EXE_MTHI_OP: begin e.whilo = 1'b1; e.hi = a;  e.lo = lo; end
            EXE_MTLO_OP: begin e.whilo = 1'b1; e.hi = hi; e.lo = a;  end
            EXE_ADD_OP, EXE_ADDI_OP, EXE_SUB_OP: begin
                if (op == EXE_SUB_OP) s = longint'($signed(a)) - longint'($signed(b));
                else                  s = longint'($signed(a)) + longint'($signed(b));
                e.wdata = s[31:0];
                if (s > 64'sd2147483647 || s < -64'sd2147483648) e.wreg = 1'b0;
            end
            EXE_ADDU_OP, EXE_ADDIU_OP: e.wdata = a + b;
            EXE_SUBU_OP: e.wdata = a - b;
            EXE_SLT_OP:  e.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            EXE_SLTU_OP: e.wdata = (a < b) ? 32'd1 : 32'd0;
            EXE_CLZ_OP, EXE_CLO_OP: begin
                n = 0;
                while (n < 32 && a[31-n] == (op == EXE_CLO_OP)) n++;
                e.wdata = 32'(n);
            end
            default: e.wdata = 32'd0;
        endcase
        return e;
    endfunction

    task automatic present(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wd, input logic wreg);
        ifc.aluop_i  = op;
        ifc.alusel_i = sel_of(op);
        ifc.reg1_i   = a;
        ifc.reg2_i   = b;
        ifc.wd_i     = wd;
        ifc.wreg_i   = wreg;
    endtask

    task automatic run_single(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] wd, input logic wreg);
        exp_t e;
        present(op, a, b, wd, wreg);
        tick();
        e = ref_alu(op, a, b, wreg, ifc.hi_i, ifc.lo_i);
        chk($sformatf("op%02h_stall", op), 64'(ifc.stall_o), 64'd0);
        chk($sformatf("op%02h_wd", op),    64'(ifc.wd_o),    64'(wd));
        chk($sformatf("op%02h_wreg", op),  64'(ifc.wreg_o),  64'(e.wreg));
        chk($sformatf("op%02h_wdata", op), 64'(ifc.wdata_o), 64'(e.wdata));
        chk($sformatf("op%02h_whilo", op), 64'(ifc.whilo_o), 64'(e.whilo));
        if (e.whilo) begin
            chk($sformatf("op%02h_hilo", op), {ifc.hi_o, ifc.lo_o}, {e.hi, e.lo});
        end
    endtask

    task automatic run_mul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wd, input logic wreg);
        logic [63:0] prod;
        int          cnt;
        int          bubble_bad;
        present(op, a, b, wd, wreg);
        tick();
        cnt = 0;
        bubble_bad = 0;
        while (ifc.stall_o === 1'b1 && cnt < 200) begin
            cnt++;
            if (ifc.wreg_o !== 1'b0 || ifc.whilo_o !== 1'b0) bubble_bad++;
            tick();
        end
        if (op == EXE_MULTU_OP) prod = {32'd0, a} * {32'd0, b};
        else                    prod = 64'(longint'($signed(a)) * longint'($signed(b)));
        chk($sformatf("mul%02h_stall_len", op), 64'(cnt), 64'd33);
        chk($sformatf("mul%02h_bubble", op), 64'(bubble_bad), 64'd0);
        chk($sformatf("mul%02h_wd", op), 64'(ifc.wd_o), 64'(wd));
        chk($sformatf("mul%02h_wreg", op), 64'(ifc.wreg_o), 64'(wreg));
        if (op == EXE_MUL_OP) begin
            chk("mul_whilo", 64'(ifc.whilo_o), 64'd0);
            chk("mul_wdata", 64'(ifc.wdata_o), 64'(prod[31:0]));
        end else begin
            chk($sformatf("mul%02h_whilo", op), 64'(ifc.whilo_o), 64'd1);
            chk($sformatf("mul%02h_hilo", op), {ifc.hi_o, ifc.lo_o}, prod);
        end
        present(EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] fwd;
        logic [7:0]  op;

        ifc.hi_i = 32'h1234_5678;
        ifc.lo_i = 32'h9ABC_DEF0;

        // Reset held with a live OR presented
        rst = 1'b1;
        present(EXE_OR_OP, 32'h0000_0F0F, 32'h0000_F000, 5'd2, 1'b1);
        repeat (2) begin
            tick();
            chk("rst_stall", 64'(ifc.stall_o), 64'd0);
            chk("rst_outs", {27'd0, ifc.wd_o, ifc.wreg_o, ifc.whilo_o, ifc.wdata_o},
                64'd0);
            chk("rst_hilo", {ifc.hi_o, ifc.lo_o}, 64'd0);
        end
        rst = 1'b0;
        run_single(EXE_OR_OP, 32'h0000_0F0F, 32'h0000_F000, 5'd2, 1'b1);
        chk("or_after_rst", 64'(ifc.wdata_o), 64'h0000_FF0F);

        // Overflow behaviour
        run_single(EXE_ADD_OP, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
        chk("add_ovf_wreg", 64'(ifc.wreg_o), 64'd0);
        run_single(EXE_ADDU_OP, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
        chk("addu_wreg", 64'(ifc.wreg_o), 64'd1);
        chk("addu_wdata", 64'(ifc.wdata_o), 64'h8000_0000);

        // Shifts and leading counts
        run_single(EXE_SRA_OP, 32'd4, 32'hF000_0000, 5'd4, 1'b1);
        chk("sra_const", 64'(ifc.wdata_o), 64'hFF00_0000);
        run_single(EXE_CLZ_OP, 32'd0, 32'd0, 5'd4, 1'b1);
        chk("clz0_const", 64'(ifc.wdata_o), 64'd32);
        run_single(EXE_CLO_OP, 32'hFFFF_0000, 32'd0, 5'd4, 1'b1);
        chk("clo_const", 64'(ifc.wdata_o), 64'd16);

        // Signed and unsigned multiply of -3 x 5
        run_mul(EXE_MULT_OP, 32'hFFFF_FFFD, 32'd5, 5'd0, 1'b0);
        chk("mult_const", {ifc.hi_o, ifc.lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_mul(EXE_MULTU_OP, 32'hFFFF_FFFD, 32'd5, 5'd0, 1'b0);
        chk("multu_const", {ifc.hi_o, ifc.lo_o}, 64'h0000_0004_FFFF_FFF1);

        // MUL into r5 then a dependent ADDU forwarded in the DONE cycle
        run_mul(EXE_MUL_OP, 32'h0001_0000, 32'h0001_0003, 5'd5, 1'b1);
        chk("mul_const", 64'(ifc.wdata_o), 64'h0003_0000);
        fwd = (ifc.wreg_o && ifc.wd_o == 5'd5) ? ifc.wdata_o : 32'd0;
        run_single(EXE_ADDU_OP, fwd, 32'd0, 5'd6, 1'b1);
        chk("fwd_addu", 64'(ifc.wdata_o), 64'h0003_0000);

        // Reset in the middle of an iteration
        present(EXE_MULT_OP, 32'd7, 32'd9, 5'd0, 1'b0);
        tick();
        tick();
        repeat (10) tick();
        chk("pre_rst_stall", 64'(ifc.stall_o), 64'd1);
        rst = 1'b1;
        present(EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        chk("midrst_stall", 64'(ifc.stall_o), 64'd0);
        chk("midrst_whilo", 64'(ifc.whilo_o), 64'd0);
        rst = 1'b0;
        tick();
        chk("postrst_stall", 64'(ifc.stall_o), 64'd0);
        chk("postrst_whilo", 64'(ifc.whilo_o), 64'd0);
        run_mul(EXE_MULT_OP, 32'hFFFF_FF00, 32'h0000_1234, 5'd0, 1'b0);

        // Signed corner cases
        run_mul(EXE_MULT_OP, 32'h8000_0000, 32'h8000_0000, 5'd0, 1'b0);
        chk("mult_minmin", {ifc.hi_o, ifc.lo_o}, 64'h4000_0000_0000_0000);
        run_mul(EXE_MULT_OP, 32'd0, 32'hFFFF_FFFB, 5'd0, 1'b0);
        chk("mult_zero_neg", {ifc.hi_o, ifc.lo_o}, 64'd0);

        // Randomized single-cycle traffic
        for (int i = 0; i < 60; i++) begin
            ifc.hi_i = $urandom;
            ifc.lo_i = $urandom;
            op = op_tab[$urandom_range(0, 21)];
            run_single(op, rnd_operand(), rnd_operand(), 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)));
        end

        // Randomized multiplies
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 2))
                0:       op = EXE_MULT_OP;
                1:       op = EXE_MULTU_OP;
                default: op = EXE_MUL_OP;
            endcase
            run_mul(op, rnd_operand(), rnd_operand(), 5'($urandom_range(1, 31)),
                    (op == EXE_MUL_OP));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
